tt_um_and_or_sequencer: RTL and testbench

TT_UM_AND_OR_SEQUENCER -- requirements
Module: tt_um_and_or_sequencer

---
 rtl/and_or_seq_pkg.sv | 30 +++
 rtl/and_or_alu.sv | 14 +
 rtl/tt_um_and_or_sequencer.sv | 162 ++++++++++++++++
 tb/tb_tt_um_and_or_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/and_or_seq_pkg.sv
// Shared types and constants for the AND/OR sequencer.
// Holds the FSM state enum, the op encoding, datapath widths and the pin
// positions of every control input and status output on the uio bus.
package and_or_seq_pkg;

  localparam int unsigned D_W   = 7;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic OP_AND = 1'b1;
  localparam logic OP_OR  = 1'b0;

  // uio_in control bit positions
  localparam int unsigned VALID_BIT     = 4;
  localparam int unsigned CLEAR_BIT     = 5;
  localparam int unsigned LAST_BIT      = 6;
  localparam int unsigned OUT_READY_BIT = 7;

  // uio_out status bit positions
  localparam int unsigned IN_READY_BIT = 0;
  localparam int unsigned BUSY_BIT     = 1;
  localparam int unsigned ERR_BIT      = 2;
  localparam int unsigned MIXED_BIT    = 3;

endpackage

// File: rtl/and_or_alu.sv
// 7-bit combinational AND/OR datapath.
// Ports: op (OP_AND selects a & b, OP_OR selects a | b), a, b -> y.
module and_or_alu
  import and_or_seq_pkg::*;
(
  input  logic           op,
  input  logic [D_W-1:0] a,
  input  logic [D_W-1:0] b,
  output logic [D_W-1:0] y
);

  assign y = (op == OP_AND) ? (a & b) : (a | b);

endmodule

// File: rtl/tt_um_and_or_sequencer.sv
// AND/OR accumulate sequencer (Tiny Tapeout style pinout).
// The first accepted operand loads the accumulator, later operands are
// folded in with AND or OR; the operand flagged last moves to HOLD, where
// the result is presented until out_ready.
// Ports:
//   clk, rst_n (synchronous, active-low), ena (ignored)
//   ui_in   [6:0] operand, [7] op (1=AND, 0=OR)
//   uio_in  [4] in_valid, [5] clear, [6] last, [7] out_ready
//   uo_out  [6:0] accumulator, [7] out_valid
//   uio_out [0] in_ready, [1] busy, [2] err, [3] mixed
//   uio_oe  constant 8'h0F
// Build option: define AND_OR_SEQ_TIMEOUT_EN to abort an ACCUM sequence
// after TIMEOUT idle cycles and raise a sticky err flag.
module tt_um_and_or_sequencer
  import and_or_seq_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t         state_q, state_d;
  logic [D_W-1:0] acc_q, acc_d;
  logic           mixed_q, mixed_d;
  logic           prev_op_q, prev_op_d;
  logic           have_op_q, have_op_d;
  logic           err;

  logic [D_W-1:0] d_in;
  logic [D_W-1:0] alu_y;
  logic           op, in_valid, clear, last, out_ready;
  logic           in_ready, accept;

  assign d_in      = ui_in[D_W-1:0];
  assign op        = ui_in[7];
  assign in_valid  = uio_in[VALID_BIT];
  assign clear     = uio_in[CLEAR_BIT];
  assign last      = uio_in[LAST_BIT];
  assign out_ready = uio_in[OUT_READY_BIT];

  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid & in_ready;

  and_or_alu u_alu (
    .op (op),
    .a  (acc_q),
    .b  (d_in),
    .y  (alu_y)
  );

`ifdef AND_OR_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign err = err_q;

  logic unused;
  assign unused = &{1'b0, ena, uio_in[3:0]};
`else
  assign err = 1'b0;

  logic unused;
  assign unused = &{1'b0, ena, uio_in[3:0], TIMEOUT};
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mixed_q   <= 1'b0;
      prev_op_q <= OP_OR;
      have_op_q <= 1'b0;
`ifdef AND_OR_SEQ_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mixed_q   <= mixed_d;
      prev_op_q <= prev_op_d;
      have_op_q <= have_op_d;
`ifdef AND_OR_SEQ_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  // Next-state and datapath update; clear beats every other request
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mixed_d   = mixed_q;
    prev_op_d = prev_op_q;
    have_op_d = have_op_q;
`ifdef AND_OR_SEQ_TIMEOUT_EN
    err_d     = err_q;
    cnt_d     = '0;
`endif

    if (clear) begin
      state_d   = IDLE;
      acc_d     = '0;
      mixed_d   = 1'b0;
      have_op_d = 1'b0;
`ifdef AND_OR_SEQ_TIMEOUT_EN
      err_d     = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d     = d_in;
            mixed_d   = 1'b0;
            have_op_d = 1'b0;
`ifdef AND_OR_SEQ_TIMEOUT_EN
            err_d     = 1'b0;
`endif
            state_d   = last ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d = alu_y;
            // only ops of ACCUM accepts are compared; the load op is ignored
            if (have_op_q && (op != prev_op_q)) mixed_d = 1'b1;
            prev_op_d = op;
            have_op_d = 1'b1;
            state_d   = last ? HOLD : ACCUM;
          end else begin
`ifdef AND_OR_SEQ_TIMEOUT_EN
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
            if (cnt_d == TIMEOUT) begin
              state_d = IDLE;
              acc_d   = '0;
              err_d   = 1'b1;
              cnt_d   = '0;
            end
`endif
          end
        end
        HOLD: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign uo_out  = {(state_q == HOLD), acc_q};
  assign uio_out = {4'b0000, mixed_q, err, (state_q != IDLE), in_ready};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_and_or_sequencer.sv
// Self-checking bench for tt_um_and_or_sequencer: directed scenarios
// followed by random traffic, all compared each cycle against a
// transaction-level model that keeps the accepted operand list of the
// current sequence and folds it to obtain the expected result.
module tb_tt_um_and_or_sequencer;

  localparam logic [7:0] V  = 8'h10;
  localparam logic [7:0] C  = 8'h20;
  localparam logic [7:0] L  = 8'h40;
  localparam logic [7:0] R  = 8'h80;
  localparam int         TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_and_or_sequencer #(.TIMEOUT(8'(TO))) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: 0 = waiting for first operand, 1 = collecting, 2 = result held
  int         phase = 0;
  logic [7:0] seq[$];
  logic [6:0] acc_m = '0;
  logic       mixed_m = 1'b0;
  logic       err_m = 1'b0;
  int         idle_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fold the operand list: first entry loads, the rest combine by op
  function automatic void fold_seq();
    logic [6:0] a;
    a = seq[0][6:0];
    mixed_m = 1'b0;
    for (int i = 1; i < seq.size(); i++) begin
      a = seq[i][7] ? (a & seq[i][6:0]) : (a | seq[i][6:0]);
      if (i >= 2 && seq[i][7] != seq[i-1][7]) mixed_m = 1'b1;
    end
    acc_m = a;
  endfunction

  function automatic void model_edge(input logic rst, input logic [7:0] ui, input logic [7:0] uio);
    if (!rst || uio[5]) begin
      phase = 0; seq.delete(); acc_m = '0; mixed_m = 1'b0; err_m = 1'b0; idle_cnt = 0;
    end else if (phase == 2) begin
      if (uio[7]) phase = 0;
    end else if (uio[4]) begin
      if (phase == 0) begin
        seq.delete();
        err_m = 1'b0;
      end
      seq.push_back(ui);
      fold_seq();
      phase = uio[6] ? 2 : 1;
      idle_cnt = 0;
    end else if (phase == 1) begin
`ifdef AND_OR_SEQ_TIMEOUT_EN
      idle_cnt++;
      if (idle_cnt == TO) begin
        phase = 0; acc_m = '0; err_m = 1'b1; idle_cnt = 0;
      end
`endif
    end
  endfunction

  // Apply inputs for one cycle, advance the model at the edge, compare after it
  task automatic cyc(input logic rst, input logic [7:0] ui, input logic [7:0] uio);
    logic [7:0] exp_uio;
    rst_n = rst; ui_in = ui; uio_in = uio;
    @(posedge clk);
    model_edge(rst, ui, uio);
    #1;
    exp_uio = {4'b0000, mixed_m, err_m, (phase != 0), (phase != 2)};
    check("uo_out", 32'(uo_out), 32'({(phase == 2), acc_m}));
    check("uio_out", 32'(uio_out), 32'(exp_uio));
    check("uio_oe", 32'(uio_oe), 32'h0F);
  endtask

  initial begin
    ena = 1'b1; rst_n = 1'b0; ui_in = '0; uio_in = '0;
    @(negedge clk);

    // reset held two cycles, with clear/valid/ready also asserted
    cyc(1'b0, 8'h55, V | C | R);
    cyc(1'b0, 8'h00, 8'h00);
    check("rst_uo", 32'(uo_out), 32'h00);
    check("rst_uio", 32'(uio_out), 32'h01);
    check("rst_oe", 32'(uio_oe), 32'h0F);

    // OR sequence
    cyc(1'b1, 8'h05, V);
    cyc(1'b1, 8'h0A, V | L);
    check("or_hold", 32'(uo_out), 32'h8F);
    cyc(1'b1, 8'h00, R);
    check("or_done", 32'(uo_out), 32'h0F);
    check("or_busy", 32'(uio_out[1]), 32'h0);

    // mixed AND/OR sequence
    cyc(1'b1, 8'h7F, V);
    cyc(1'b1, 8'hBC, V);
    cyc(1'b1, 8'h01, V | L);
    check("mix_uo", 32'(uo_out), 32'hBD);
    check("mix_flag", 32'(uio_out[3]), 32'h1);

    // backpressure in HOLD: operands offered but never taken
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'h00, V);
      check("bp_ready", 32'(uio_out[0]), 32'h0);
      check("bp_uo", 32'(uo_out), 32'hBD);
    end
    cyc(1'b1, 8'h00, R);

    // clear wins over a simultaneous accept mid-ACCUM
    cyc(1'b1, 8'h2A, V);
    cyc(1'b1, 8'h00, V);
    cyc(1'b1, 8'h00, 8'h00);
    check("clr_pre", 32'(uo_out), 32'h2A);
    cyc(1'b1, 8'hFF, V | C | L);
    check("clr_acc", 32'(uo_out), 32'h00);
    check("clr_busy", 32'(uio_out[1]), 32'h0);
    check("clr_mixed", 32'(uio_out[3]), 32'h0);

    // idle in ACCUM
    cyc(1'b1, 8'h33, V);
`ifdef AND_OR_SEQ_TIMEOUT_EN
    for (int i = 0; i < TO; i++) cyc(1'b1, 8'h00, 8'h00);
    check("to_err", 32'(uio_out[2]), 32'h1);
    check("to_busy", 32'(uio_out[1]), 32'h0);
    check("to_acc", 32'(uo_out[6:0]), 32'h0);
`else
    for (int i = 0; i < 300; i++) cyc(1'b1, 8'h00, 8'h00);
    check("noto_busy", 32'(uio_out[1]), 32'h1);
    check("noto_acc", 32'(uo_out), 32'h33);
`endif
    cyc(1'b1, 8'h00, C);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] ui;
      logic [7:0] uio;
      logic       rst;
      ui  = 8'($urandom);
      uio = 8'($urandom) & 8'h0F;
      if ($urandom_range(0, 99) < 55) uio |= V;
      if ($urandom_range(0, 99) < 3)  uio |= C;
      if ($urandom_range(0, 99) < 25) uio |= L;
      if ($urandom_range(0, 99) < 35) uio |= R;
      rst = ($urandom_range(0, 199) != 0);
      cyc(rst, ui, uio);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
